// File: rtl/jtframe_ioctl_sdram.sv
// jtframe_ioctl_sdram: schedules ioctl download writes and NVRAM upload reads
// onto the SDRAM programming port. Download bytes are packed into 16-bit words
// with byte enables and queued in a small FIFO; upload bytes are served from a
// one-word cache that is refilled from SDRAM whenever the word address moves.
module jtframe_ioctl_sdram #(
  parameter int AW    = 22,
  parameter int DEPTH = 4
) (
  input  logic          clk_rom,
  input  logic          rst_n,
  input  logic          ioctl_rom,
  input  logic          ioctl_ram,
  input  logic          ioctl_upload,
  input  logic          ioctl_wr,
  input  logic [25:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic [7:0]    ioctl_din,
  output logic [AW-1:0] prog_addr,
  output logic [15:0]   prog_data,
  output logic [1:0]    prog_be,
  output logic          prog_we,
  output logic          prog_rd,
  input  logic          prog_ack,
  input  logic          prog_rdy,
  input  logic [15:0]   prog_q,
  output logic          busy,
  output logic          done,
  output logic          overflow
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic [1:0]    be;
  } entry_t;

  typedef enum logic [1:0] {IDLE, WR, RD, RDW} state_t;

  // edge detection
  logic act, act_q, act_rise, act_fall, upl_q, upl_rise;
  logic [AW-1:0] waddr;
  logic dl_wr;

  // packer
  logic   held_q, held_d, pend_q, pend_d;
  entry_t hold_q, hold_d, pend_e_q, pend_e_d, push_e;
  logic   push;

  // fifo
  entry_t mem [DEPTH];
  logic [PW:0] wr_ptr_q, rd_ptr_q;
  logic empty, full, do_push, pop;
  entry_t head;
  logic ovf_q;

  // fsm / cache / done
  state_t state_q, state_d;
  logic [AW-1:0] rd_addr_q, tag_q;
  logic [15:0]   cache_q;
  logic cvld_q, rd_start, fill;
  logic armed_q, done_q, done_cond;

  // address bits above the SDRAM word space are intentionally ignored
  logic unused_hi;
  assign unused_hi = ^ioctl_addr[25:AW+1];

  assign act      = ioctl_rom | ioctl_ram;
  assign act_rise = act & ~act_q;
  assign act_fall = ~act & act_q;
  assign upl_rise = ioctl_upload & ~upl_q;
  assign waddr    = ioctl_addr[AW:1];
  assign dl_wr    = ioctl_wr & act & ~ioctl_upload;

  // edge-detect history for act and upload
  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      act_q <= 1'b0;
      upl_q <= 1'b0;
    end else begin
      act_q <= act;
      upl_q <= ioctl_upload;
    end
  end

  // byte packer: decide what (if anything) is pushed this cycle and what is held
  always_comb begin
    push     = 1'b0;
    push_e   = '0;
    held_d   = held_q;
    hold_d   = hold_q;
    pend_d   = pend_q;
    pend_e_d = pend_e_q;
    if (pend_q) begin
      // second half of a flush-plus-odd-byte strobe
      push   = 1'b1;
      push_e = pend_e_q;
      pend_d = 1'b0;
    end else if (dl_wr) begin
      if (!ioctl_addr[0]) begin
        if (held_q && hold_q.addr != waddr) begin
          push   = 1'b1;
          push_e = hold_q;
        end
        held_d       = 1'b1;
        hold_d.addr  = waddr;
        hold_d.data  = {8'h00, ioctl_dout};
        hold_d.be    = 2'b01;
      end else if (held_q && hold_q.addr == waddr) begin
        push        = 1'b1;
        push_e.addr = waddr;
        push_e.data = {ioctl_dout, hold_q.data[7:0]};
        push_e.be   = 2'b11;
        held_d      = 1'b0;
      end else if (held_q) begin
        push          = 1'b1;
        push_e        = hold_q;
        held_d        = 1'b0;
        pend_d        = 1'b1;
        pend_e_d.addr = waddr;
        pend_e_d.data = {ioctl_dout, 8'h00};
        pend_e_d.be   = 2'b10;
      end else begin
        push        = 1'b1;
        push_e.addr = waddr;
        push_e.data = {ioctl_dout, 8'h00};
        push_e.be   = 2'b10;
      end
    end else if (act_fall && held_q) begin
      push   = 1'b1;
      push_e = hold_q;
      held_d = 1'b0;
    end
  end

  // packer state
  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      held_q   <= 1'b0;
      hold_q   <= '0;
      pend_q   <= 1'b0;
      pend_e_q <= '0;
    end else begin
      held_q   <= held_d;
      hold_q   <= hold_d;
      pend_q   <= pend_d;
      pend_e_q <= pend_e_d;
    end
  end

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign do_push = push & ~full;
  assign head    = mem[rd_ptr_q[PW-1:0]];

  // fifo storage; contents are don't-care until the pointers cover them
  always_ff @(posedge clk_rom) begin
    if (do_push) mem[wr_ptr_q[PW-1:0]] <= push_e;
  end

  // fifo pointers and sticky overflow (a full fifo drops even if popping)
  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && full) ovf_q <= 1'b1;
      else if (act_rise) ovf_q <= 1'b0;
    end
  end

  // scheduler next state and request outputs; idle drives zeros
  always_comb begin
    state_d   = state_q;
    prog_we   = 1'b0;
    prog_rd   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    prog_be   = '0;
    pop       = 1'b0;
    rd_start  = 1'b0;
    fill      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) state_d = WR;
        else if (!held_q && !pend_q && ioctl_upload && !cvld_q) begin
          state_d  = RD;
          rd_start = 1'b1;
        end
      end
      WR: begin
        prog_we   = 1'b1;
        prog_addr = head.addr;
        prog_data = head.data;
        prog_be   = head.be;
        if (prog_ack) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      RD: begin
        prog_rd   = 1'b1;
        prog_addr = rd_addr_q;
        if (prog_ack) state_d = RDW;
      end
      RDW: begin
        if (prog_rdy) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // scheduler state and latched read address (keeps prog_addr stable in RD)
  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (rd_start) rd_addr_q <= waddr;
    end
  end

  // upload cache: fill on read data, drop when the word address moves away
  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      cache_q <= '0;
      tag_q   <= '0;
      cvld_q  <= 1'b0;
    end else begin
      if (fill) begin
        cache_q <= prog_q;
        tag_q   <= rd_addr_q;
        cvld_q  <= 1'b1;
      end else if (cvld_q && tag_q != waddr) begin
        cvld_q <= 1'b0;
      end
      if (upl_rise) cvld_q <= 1'b0;
    end
  end

  // only serve data for the word actually cached, so a stale byte never leaks
  assign ioctl_din = (cvld_q && tag_q == waddr) ?
                     (ioctl_addr[0] ? cache_q[15:8] : cache_q[7:0]) : 8'h00;

  assign done_cond = ~act & armed_q & ~held_q & ~pend_q & empty & (state_q == IDLE);

  // done: armed by the end of a download, fires once after the fifo drains
  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= done_cond;
      if (act_fall)       armed_q <= 1'b1;
      else if (act_rise)  armed_q <= 1'b0;
      else if (done_cond) armed_q <= 1'b0;
    end
  end

  assign busy     = held_q | pend_q | ~empty | (state_q != IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_jtframe_ioctl_sdram.sv
// Directed bench for jtframe_ioctl_sdram with a small SDRAM model and a write
// scoreboard: expected writes are queued as bytes are sent and checked when
// the model accepts a prog_we request.
module tb_jtframe_ioctl_sdram;

  logic        clk_rom = 1'b0;
  logic        rst_n = 1'b0;
  logic        ioctl_rom = 1'b0, ioctl_ram = 1'b0, ioctl_upload = 1'b0, ioctl_wr = 1'b0;
  logic [25:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [7:0]  ioctl_din;
  logic [21:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_be;
  logic        prog_we, prog_rd;
  logic        prog_ack = 1'b0, prog_rdy = 1'b0;
  logic [15:0] prog_q = '0;
  logic        busy, done, overflow;

  typedef struct packed {
    logic [21:0] a;
    logic [15:0] d;
    logic [1:0]  be;
  } wexp_t;

  wexp_t       sb[$];
  wexp_t       e;
  int          checks = 0, errors = 0;
  int          nwr = 0, nrd = 0, ndone = 0;
  int          nw0, nr0, nd0;
  bit          ack_en = 1'b0;
  bit          rd_wait = 1'b0;
  logic [21:0] rd_a;
  logic [15:0] mval;

  jtframe_ioctl_sdram #(.AW(22), .DEPTH(4)) dut (
    .clk_rom(clk_rom), .rst_n(rst_n),
    .ioctl_rom(ioctl_rom), .ioctl_ram(ioctl_ram), .ioctl_upload(ioctl_upload),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_din(ioctl_din), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_be(prog_be), .prog_we(prog_we), .prog_rd(prog_rd),
    .prog_ack(prog_ack), .prog_rdy(prog_rdy), .prog_q(prog_q),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk_rom = ~clk_rom;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [21:0] a);
    return (a == 22'd3) ? 16'hBEEF : {a[7:0] ^ 8'h5A, a[7:0]};
  endfunction

  // SDRAM model on the falling edge: acks requests, returns read data a cycle later
  always @(negedge clk_rom) begin
    if (done) ndone++;
    prog_ack = 1'b0;
    prog_rdy = 1'b0;
    if (!rst_n) begin
      rd_wait = 1'b0;
    end else if (rd_wait) begin
      prog_rdy = 1'b1;
      prog_q   = model(rd_a);
      rd_wait  = 1'b0;
    end else if (prog_we && ack_en) begin
      nwr++;
      chk("wr_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wr_entry", 64'({prog_addr, prog_data, prog_be}), 64'(e));
      end
      prog_ack = 1'b1;
    end else if (prog_rd) begin
      nrd++;
      rd_a     = prog_addr;
      rd_wait  = 1'b1;
      prog_ack = 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_rom);
    #1;
  endtask

  task automatic send(input logic [25:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick(1);
    ioctl_wr   = 1'b0;
    tick(2);
  endtask

  task automatic expw(input logic [21:0] a, input logic [15:0] d, input logic [1:0] be);
    sb.push_back('{a: a, d: d, be: be});
  endtask

  initial begin
    // reset state
    tick(2);
    chk("rst_we", prog_we, 0);
    chk("rst_rd", prog_rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_din", ioctl_din, 0);
    chk("rst_addr", prog_addr, 0);
    chk("rst_be", prog_be, 0);
    rst_n = 1'b1;
    tick(2);

    // two bytes merging into one word, immediate ack
    ack_en = 1'b1;
    nd0 = ndone;
    ioctl_rom = 1'b1;
    tick(1);
    expw(22'd0, 16'h2211, 2'b11);
    send(26'd0, 8'h11);
    ioctl_addr = 26'd1;
    ioctl_dout = 8'h22;
    ioctl_wr   = 1'b1;
    tick(1);
    ioctl_wr   = 1'b0;
    chk("t1_we_edge1", prog_we, 0);
    chk("t1_busy", busy, 1);
    tick(1);
    chk("t1_we_edge2", prog_we, 1);
    chk("t1_addr", prog_addr, 0);
    chk("t1_data", prog_data, 16'h2211);
    chk("t1_be", prog_be, 2'b11);
    tick(3);
    ioctl_rom = 1'b0;
    tick(6);
    chk("t1_done_once", ndone - nd0, 1);
    chk("t1_writes", nwr, 1);
    chk("t1_idle", busy, 0);

    // lone low byte then lone high byte in another word
    nw0 = nwr;
    nd0 = ndone;
    ioctl_rom = 1'b1;
    tick(1);
    expw(22'd2, 16'h00AA, 2'b01);
    expw(22'd4, 16'hBB00, 2'b10);
    send(26'd4, 8'hAA);
    send(26'd9, 8'hBB);
    ioctl_rom = 1'b0;
    tick(12);
    chk("t2_writes", nwr - nw0, 2);
    chk("t2_done_once", ndone - nd0, 1);
    chk("t2_ovf", overflow, 0);

    // overflow: ack withheld, 6 words into a 4-deep fifo
    ack_en = 1'b0;
    nw0 = nwr;
    nd0 = ndone;
    ioctl_rom = 1'b1;
    tick(1);
    for (int w = 0; w < 4; w++)
      expw(22'h20 + 22'(w), {8'h31 + 8'(2*w), 8'h30 + 8'(2*w)}, 2'b11);
    for (int i = 0; i < 12; i++)
      send(26'h40 + 26'(i), 8'h30 + 8'(i));
    ioctl_rom = 1'b0;
    tick(4);
    chk("t3_ovf_set", overflow, 1);
    chk("t3_busy", busy, 1);
    chk("t3_no_writes", nwr - nw0, 0);
    chk("t3_no_done_yet", ndone - nd0, 0);
    ack_en = 1'b1;
    tick(20);
    chk("t3_writes", nwr - nw0, 4);
    chk("t3_sb_drained", sb.size(), 0);
    chk("t3_ovf_sticky", overflow, 1);
    chk("t3_done_once", ndone - nd0, 1);
    ioctl_rom = 1'b1;
    tick(2);
    chk("t3_ovf_clear", overflow, 0);
    ioctl_rom = 1'b0;
    tick(4);

    // upload: both bytes of word 3 from a single read
    nr0 = nrd;
    ioctl_upload = 1'b1;
    ioctl_addr   = 26'd6;
    tick(8);
    chk("t4_din_lo", ioctl_din, 8'hEF);
    chk("t4_reads1", nrd - nr0, 1);
    ioctl_addr = 26'd7;
    ioctl_wr   = 1'b1;
    tick(1);
    ioctl_wr   = 1'b0;
    tick(4);
    chk("t4_din_hi", ioctl_din, 8'hBE);
    chk("t4_reads_still1", nrd - nr0, 1);
    ioctl_addr = 26'd8;
    tick(1);
    chk("t4_rd_edge1", prog_rd, 0);
    tick(1);
    chk("t4_rd_edge2", prog_rd, 1);
    chk("t4_rd_addr", prog_addr, 4);
    tick(6);
    mval = model(22'd4);
    chk("t4_din_w4", ioctl_din, mval[7:0]);
    chk("t4_reads2", nrd - nr0, 2);
    ioctl_upload = 1'b0;
    tick(2);

    // asynchronous reset in the middle of a pending write
    ack_en = 1'b0;
    nw0 = nwr;
    ioctl_rom = 1'b1;
    tick(1);
    for (int i = 0; i < 10; i++)
      send(26'h80 + 26'(i), 8'(i));
    tick(1);
    chk("t5_we_pending", prog_we, 1);
    chk("t5_ovf_set", overflow, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_we_async", prog_we, 0);
    chk("t5_busy_async", busy, 0);
    chk("t5_ovf_async", overflow, 0);
    ioctl_rom = 1'b0;
    tick(2);
    rst_n  = 1'b1;
    ack_en = 1'b1;
    tick(15);
    chk("t5_no_stale", nwr - nw0, 0);
    chk("t5_idle", busy, 0);

    chk("sb_empty_end", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
